reg_wb_queue: RTL and testbench
===============================

// Module: reg_wb_queue
// PURPOSE
//  Write-back queue sitting directly upstream of the 16x32 register bank.
//  Accepts register write requests (addr, data) over a valid/ready handshake,
//  buffers them in a DEPTH-entry FIFO, and drains one per cycle onto the
//  bank's one-hot write-enable and data inputs. Also reports whether a write
//  to a given register is still pending, so decode can stall on RAW hazards.
// PARAMETERS
//  DEPTH   4    FIFO entries; power of 2, >= 2
//  ADDR_W  4    register address width
//  NREG    16   number of registers (2**ADDR_W); width of wr
//  DATA_W  32   register data width
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       asynchronous, active-low reset
//  in_valid     in   1       write request valid
//  in_ready     out  1       queue can accept (= count < DEPTH)
//  in_addr      in   ADDR_W  destination register
//  in_data      in   DATA_W  write data
//  wb_hold      in   1       1 = do not pop this cycle
//  wr           out  NREG    one-hot write enable to register bank (registered)
//  wb_data      out  DATA_W  write data to register bank (registered)
//  chk_addr     in   ADDR_W  register to query for pending writes
//  chk_pending  out  1       1 = a write to chk_addr is queued or on wr/wb_data
//  busy         out  1       count != 0 or wr != 0
// BEHAVIOUR
//  - Reset (rst=0, async): count, head, tail = 0; wr = 0; wb_data = 0.
//    Queued entries are discarded. in_ready=1, busy=0, chk_pending=0.
//  - Accept: in_valid & in_ready at posedge. in_addr==0 -> accepted but
//    dropped (r0 is hardwired); count, tail unchanged, no wr pulse ever.
//    Otherwise entry written at tail; tail = (tail+1) mod DEPTH.
//  - Pop: count!=0 & !wb_hold at posedge -> wr <= 1<<head.addr,
//    wb_data <= head.data, head = (head+1) mod DEPTH.
//    Otherwise wr <= 0; wb_data holds its last value.
//  - wr is a single-cycle pulse per entry; at most one bit set.
//  - Latency: accept at edge E -> wr asserted for the cycle after E+1
//    (i.e. driven from edge E+1) when wb_hold=0; bank captures at E+2.
//    No combinational bypass from in_* to wr.
//  - Simultaneous accept and pop: both occur; count unchanged; FIFO order kept.
//  - Full (count==DEPTH): in_ready=0 even if a pop occurs this cycle.
//  - Empty: nothing popped; wb_hold ignored.
//  - Multiple writes to same address drain in order; last one wins in bank.
//  - chk_pending (combinational): chk_addr!=0 and (any valid FIFO entry has
//    addr==chk_addr, or wr[chk_addr]==1). chk_addr==0 -> 0.
//  - in_ready, busy, chk_pending depend only on registered state and chk_addr;
//    no path from in_valid to in_ready.
// TESTING
//  1 Reset mid-drain: 3 entries queued, assert rst=0 -> wr=0, wb_data=0,
//    busy=0, in_ready=1 immediately; after release no wr pulses appear.
//  2 Single write addr=5 data=32'hDEADBEEF accepted at edge k -> wr=16'h0020,
//    wb_data=DEADBEEF for exactly one cycle after edge k+1; bank rd_addr=5
//    returns DEADBEEF after edge k+2.
//  3 wb_hold=1, push addr 1,2,3,4 -> in_ready=0 after 4th; 5th (addr 9) held;
//    drop hold -> wr=0002,0004,0008,0010 on consecutive cycles, then 0200.
//  4 Write addr=0 data=FFFFFFFF -> accepted (in_ready=1), no wr pulse, busy=0.
//  5 wb_hold=1, queue addr 7: chk_addr=7 -> 1, chk_addr=8 -> 0, chk_addr=0 -> 0;
//    release -> chk_pending(7) stays 1 through the wr=0080 cycle, then 0.
//  6 200 random push/pop cycles with random wb_hold, addr 0..15 -> wr sequence
//    equals reference FIFO model (addr 0 removed), count never exceeds 4,
//    pointer wrap exercised, final bank contents match model.

Source files
------------

// File: rtl/reg_wb_queue.sv
// -----------------------------------------------------------------------------
// reg_wb_queue
//
// Write-back queue placed in front of the register bank. Write requests
// (address, data) come in over a valid/ready handshake and are held in a
// DEPTH-entry circular FIFO. One entry per cycle drains onto the bank as a
// registered one-hot write enable plus write data. The block also reports
// whether a write to a queried register is still in flight, so decode can
// stall on read-after-write hazards.
//
// Writes to register 0 are accepted but discarded, because r0 is hardwired.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     write request valid
//   in_ready_o     queue can accept a request (count < DEPTH)
//   in_addr_i      destination register of the request
//   in_data_i      write data of the request
//   wb_hold_i      1 = do not pop this cycle
//   wr_o           one-hot write enable to the bank (registered, 1-cycle pulse)
//   wb_data_o      write data to the bank (registered, holds when idle)
//   chk_addr_i     register to check for pending writes
//   chk_pending_o  a write to chk_addr_i is queued or currently on wr_o
//   busy_o         queue not empty or a write pulse is on wr_o
// -----------------------------------------------------------------------------
module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              wb_hold_i,
    output logic [NREG-1:0]   wr_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic [ADDR_W-1:0] chk_addr_i,
    output logic              chk_pending_o,
    output logic              busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage; contents need no reset because validity comes from the
    // head pointer and count only.
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NREG-1:0]   wr_q, wr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic accept;
    logic push;
    logic pop;

    // Ready depends only on the registered count. A pop in the same cycle
    // does not free a slot for a new request.
    assign in_ready_o = (count_q < CNT_W'(DEPTH));
    assign accept     = in_valid_i & in_ready_o;
    // Requests for r0 complete the handshake but never enter the FIFO.
    assign push       = accept & (in_addr_i != '0);
    assign pop        = (count_q != '0) & ~wb_hold_i;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_d      = '0;
        wb_data_d = wb_data_q;

        if (pop) begin
            head_d    = head_q + PTR_W'(1);
            wr_d      = NREG'(1) << addr_mem[head_q];
            wb_data_d = data_mem[head_q];
        end

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end

        // A push and a pop in the same cycle leave the count unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_q      <= '0;
            wb_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_q      <= wr_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[tail_q] <= in_addr_i;
            data_mem[tail_q] <= in_data_i;
        end
    end

    // Hazard check. A slot holds a live entry when its distance from head,
    // taken modulo DEPTH, is below the count.
    logic [DEPTH-1:0] hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PTR_W-1:0] offset;
            logic             live;
            assign offset  = PTR_W'(gi) - head_q;
            assign live    = ({1'b0, offset} < count_q);
            assign hit[gi] = live & (addr_mem[gi] == chk_addr_i);
        end
    endgenerate

    assign chk_pending_o = (chk_addr_i != '0) & ((|hit) | wr_q[chk_addr_i]);
    assign busy_o        = (count_q != '0) | (|wr_q);
    assign wr_o          = wr_q;
    assign wb_data_o     = wb_data_q;

endmodule

// File: tb/tb_reg_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_queue
//
// Self-checking bench for reg_wb_queue. A reference model holds the pending
// writes as a queue of (addr, data) entries. It also holds the write pulse
// expected on the bank side and a model of the register bank. A separate
// array captures what the DUT actually writes to the bank.
// -----------------------------------------------------------------------------
module tb_reg_wb_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 4;
    localparam int NREG   = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              wb_hold;
    logic [NREG-1:0]   wr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_pending;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_wb_queue #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .NREG  (NREG),
        .DATA_W(DATA_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_addr_i    (in_addr),
        .in_data_i    (in_data),
        .wb_hold_i    (wb_hold),
        .wr_o         (wr),
        .wb_data_o    (wb_data),
        .chk_addr_i   (chk_addr),
        .chk_pending_o(chk_pending),
        .busy_o       (busy)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic [NREG-1:0]   m_wr  = '0;
    logic [DATA_W-1:0] m_wbd = '0;
    logic [DATA_W-1:0] m_bank [NREG];
    logic [DATA_W-1:0] t_bank [NREG];
    bit                verbose = 1'b0;

    // Bank as seen by the DUT outputs
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++)
            if (wr[i]) t_bank[i] <= wb_data;
    end

    function automatic int oh_idx(input logic [NREG-1:0] v);
        for (int i = 0; i < NREG; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic m_pending(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
        if (m_wr[a]) return 1'b1;
        foreach (mq[i])
            if (mq[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock edge. The model state is updated from the inputs
    // that were present before the edge. The task returns 1 ns after the edge.
    task automatic tick();
        ent_t              e;
        logic              acc;
        logic              pp;
        logic [NREG-1:0]   nwr;
        logic [DATA_W-1:0] nwbd;
        acc  = in_valid && (mq.size() < DEPTH);
        pp   = (mq.size() != 0) && !wb_hold;
        nwr  = '0;
        nwbd = m_wbd;
        if (m_wr != 0) m_bank[oh_idx(m_wr)] = m_wbd;
        if (pp) begin
            e    = mq.pop_front();
            nwr  = NREG'(1) << e.a;
            nwbd = e.d;
            if (verbose) $display("wb   addr=%0d data=%08h", e.a, e.d);
        end
        if (acc && in_addr != 0) begin
            e.a = in_addr;
            e.d = in_data;
            mq.push_back(e);
        end
        if (acc && verbose) $display("push addr=%0d data=%08h", in_addr, in_data);
        @(posedge clk);
        m_wr  = nwr;
        m_wbd = nwbd;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mq.delete();
        m_wr  = '0;
        m_wbd = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        in_valid = 0; in_addr = 0; in_data = 0; wb_hold = 0; chk_addr = 0;
        #12;
        checks++; if (wr !== 16'h0) begin failures++; $display("FAIL reset_wr got=%h exp=0000", wr); end
        checks++; if (wb_data !== 32'h0) begin failures++; $display("FAIL reset_wbdata got=%h exp=0", wb_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_single();
        in_valid = 1; in_addr = 4'd5; in_data = 32'hDEADBEEF; wb_hold = 0; chk_addr = 4'd5;
        tick();                                   // edge k: accepted
        in_valid = 0;
        #1;
        checks++; if (wr !== 16'h0) begin failures++; $display("FAIL single_early got=%h exp=0000", wr); end
        checks++; if (chk_pending !== 1'b1) begin failures++; $display("FAIL single_pend got=%b exp=1", chk_pending); end
        tick();                                   // edge k+1: popped
        checks++; if (wr !== 16'h0020) begin failures++; $display("FAIL single_wr got=%h exp=0020", wr); end
        checks++; if (wb_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", wb_data); end
        tick();                                   // edge k+2: bank captures
        checks++; if (wr !== 16'h0) begin failures++; $display("FAIL single_pulse got=%h exp=0000", wr); end
        checks++; if (t_bank[5] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_bank got=%h exp=deadbeef", t_bank[5]); end
        $display("single write addr=5 done");
    endtask

    task automatic test_full_hold();
        logic [NREG-1:0] exp_wr [5];
        exp_wr[0] = 16'h0002; exp_wr[1] = 16'h0004; exp_wr[2] = 16'h0008;
        exp_wr[3] = 16'h0010; exp_wr[4] = 16'h0200;
        wb_hold = 1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_addr = ADDR_W'(i); in_data = 32'h1000 + 32'(i);
            tick();
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        in_addr = 4'd9; in_data = 32'h9999;
        tick();                                   // held: queue full
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready2 got=%b exp=0", in_ready); end
        checks++; if (wr !== 16'h0) begin failures++; $display("FAIL full_hold_wr got=%h exp=0000", wr); end
        wb_hold = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) in_valid = 0;             // addr 9 taken on the second edge
            checks++;
            if (wr !== exp_wr[i]) begin failures++; $display("FAIL full_drain%0d got=%h exp=%h", i, wr, exp_wr[i]); end
        end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_idle_busy got=%b exp=0", busy); end
        checks++; if (t_bank[4] !== 32'h1004) begin failures++; $display("FAIL full_bank4 got=%h exp=00001004", t_bank[4]); end
        $display("full/hold drain done");
    endtask

    task automatic test_r0();
        wb_hold = 0; in_valid = 1; in_addr = 4'd0; in_data = 32'hFFFFFFFF;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (wr !== 16'h0) begin failures++; $display("FAIL r0_wr got=%h exp=0000", wr); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL r0_busy got=%b exp=0", busy); end
            tick();
        end
        $display("r0 write dropped");
    endtask

    task automatic test_pending();
        wb_hold = 1; in_valid = 1; in_addr = 4'd7; in_data = $urandom;
        tick();
        in_valid = 0;
        chk_addr = 4'd7; #1;
        checks++; if (chk_pending !== 1'b1) begin failures++; $display("FAIL pend_q7 got=%b exp=1", chk_pending); end
        chk_addr = 4'd8; #1;
        checks++; if (chk_pending !== 1'b0) begin failures++; $display("FAIL pend_q8 got=%b exp=0", chk_pending); end
        chk_addr = 4'd0; #1;
        checks++; if (chk_pending !== 1'b0) begin failures++; $display("FAIL pend_q0 got=%b exp=0", chk_pending); end
        chk_addr = 4'd7; wb_hold = 0; #1;
        tick();
        checks++; if (wr !== 16'h0080) begin failures++; $display("FAIL pend_wr got=%h exp=0080", wr); end
        checks++; if (chk_pending !== 1'b1) begin failures++; $display("FAIL pend_onwr got=%b exp=1", chk_pending); end
        tick();
        checks++; if (chk_pending !== 1'b0) begin failures++; $display("FAIL pend_after got=%b exp=0", chk_pending); end
        $display("pending check addr=7 done");
    endtask

    task automatic test_reset_mid_drain();
        wb_hold = 1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1; in_addr = ADDR_W'(i + 10); in_data = $urandom;
            tick();
        end
        in_valid = 0; wb_hold = 0; chk_addr = 4'd12;
        tick();                                   // first entry on wr
        checks++; if (wr !== 16'h0800) begin failures++; $display("FAIL rmd_first got=%h exp=0800", wr); end
        apply_reset();
        #1;
        checks++; if (wr !== 16'h0) begin failures++; $display("FAIL rmd_wr got=%h exp=0000", wr); end
        checks++; if (wb_data !== 32'h0) begin failures++; $display("FAIL rmd_data got=%h exp=0", wb_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmd_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmd_ready got=%b exp=1", in_ready); end
        checks++; if (chk_pending !== 1'b0) begin failures++; $display("FAIL rmd_pend got=%b exp=0", chk_pending); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (wr !== 16'h0) begin failures++; $display("FAIL rmd_after%0d got=%h exp=0000", i, wr); end
        end
        $display("reset mid-drain done");
    endtask

    task automatic test_random();
        logic exp_pend;
        verbose = 1'b1;
        for (int c = 0; c < 200; c++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_addr  = ADDR_W'($urandom_range(0, NREG - 1));
            in_data  = $urandom;
            wb_hold  = ($urandom_range(0, 2) == 0);
            chk_addr = ADDR_W'($urandom_range(0, NREG - 1));
            #1;
            exp_pend = m_pending(chk_addr);
            checks++; if (wr !== m_wr) begin failures++; $display("FAIL rnd_wr c=%0d got=%h exp=%h", c, wr, m_wr); end
            checks++; if (wr != 0 && wb_data !== m_wbd) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, wb_data, m_wbd); end
            checks++; if (in_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, mq.size() < DEPTH); end
            checks++; if (busy !== (mq.size() != 0 || m_wr != 0)) begin failures++; $display("FAIL rnd_busy c=%0d got=%b", c, busy); end
            checks++; if (chk_pending !== exp_pend) begin failures++; $display("FAIL rnd_pend c=%0d addr=%0d got=%b exp=%b", c, chk_addr, chk_pending, exp_pend); end
            tick();
        end
        in_valid = 0; wb_hold = 0;
        for (int i = 0; i < DEPTH + 3; i++) tick();
        verbose = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_final_busy got=%b exp=0", busy); end
        for (int r = 1; r < NREG; r++) begin
            checks++;
            if (t_bank[r] !== m_bank[r]) begin failures++; $display("FAIL rnd_bank r%0d got=%h exp=%h", r, t_bank[r], m_bank[r]); end
        end
        $display("random test done");
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_bank[i] = '0;
            t_bank[i] = '0;
        end
        test_reset();
        test_single();
        test_full_hold();
        test_r0();
        test_pending();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
